// File: rtl/multi_divid_pkg.sv
// Shared op codes, FSM states and operand-decode helpers for the iterative mul/div unit.
package multi_divid_pkg;

    localparam logic [1:0] OP_SDIV = 2'b00;
    localparam logic [1:0] OP_SMUL = 2'b01;
    localparam logic [1:0] OP_UDIV = 2'b10;
    localparam logic [1:0] OP_UMUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Per-operation flags captured with the operands and consumed in FIX
    typedef struct packed {
        logic neg;      // product / quotient must be negated
        logic rem_neg;  // remainder takes the sign of the dividend
        logic dz;       // divide by zero
        logic ovf;      // signed division overflow
    } flags_t;

    function automatic logic is_div(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_signed(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/multi_divid_seq_md_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on a 2N-bit accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module md_iter_step #(
    parameter int N = 5
) (
    input  logic           div,
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   opnd,
    output logic [2*N-1:0] acc_nxt
);

    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic [N:0]   sum;
    logic [N:0]   rem_sh;
    logic [N-1:0] rem_sub;
    logic         ge;

    assign hi      = acc[2*N-1:N];
    assign lo      = acc[N-1:0];
    assign sum     = {1'b0, hi} + {1'b0, opnd};
    assign rem_sh  = {hi, lo[N-1]};
    assign ge      = (rem_sh >= {1'b0, opnd});
    // A successful trial subtraction always leaves a value below the divisor, so N bits suffice
    assign rem_sub = rem_sh[N-1:0] - opnd;

    always_comb begin
        acc_nxt = '0;
        if (div) begin
            if (ge) acc_nxt = {rem_sub, lo[N-2:0], 1'b1};
            else    acc_nxt = {rem_sh[N-1:0], lo[N-2:0], 1'b0};
        end else if (lo[0]) begin
            acc_nxt = {sum, lo[N-1:1]};
        end else begin
            acc_nxt = {1'b0, hi, lo[N-1:1]};
        end
    end

endmodule

// File: rtl/multi_divid_seq.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle, with start/done handshake.
// Latency: done pulses N+1 edges after the start-capture edge for every op, error cases included.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module multi_divid_seq
    import multi_divid_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] m,
    output logic [N-1:0] r,
    output logic         error
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_l;
    logic [N-1:0]   a_l;
    logic [N-1:0]   opnd;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_nxt;
    flags_t         flags;

    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    flags_t         flags_in;

    logic [2*N-1:0] prod;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
    logic [N-1:0]   m_fix;
    logic [N-1:0]   r_fix;
    logic           err_fix;

    md_iter_step #(.N(N)) u_step (
        .div     (is_div(op_l)),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        a_neg          = is_signed(op) & a[N-1];
        b_neg          = is_signed(op) & b[N-1];
        a_mag          = a_neg ? -a : a;
        b_mag          = b_neg ? -b : b;
        flags_in.neg     = a_neg ^ b_neg;
        flags_in.rem_neg = a_neg;
        flags_in.dz      = is_div(op) && (b == '0);
        flags_in.ovf     = (op == OP_SDIV) && (a == MIN_NEG) && (b == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign fix-up and special-case overrides applied on the way into the output registers
    always_comb begin
        prod    = flags.neg ? -acc : acc;
        quo     = acc[N-1:0];
        rem     = acc[2*N-1:N];
        m_fix   = prod[2*N-1:N];
        r_fix   = prod[N-1:0];
        err_fix = 1'b0;
        if (flags.dz) begin
            m_fix   = '1;
            r_fix   = a_l;
            err_fix = 1'b1;
        end else if (flags.ovf) begin
            m_fix   = MIN_NEG;
            r_fix   = '0;
            err_fix = 1'b1;
        end else if (is_div(op_l)) begin
            m_fix = flags.neg     ? -quo : quo;
            r_fix = flags.rem_neg ? -rem : rem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_l  <= '0;
            a_l   <= '0;
            opnd  <= '0;
            acc   <= '0;
            flags <= '0;
            done  <= 1'b0;
            m     <= '0;
            r     <= '0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_l  <= op;
                        a_l   <= a;
                        flags <= flags_in;
                        cnt   <= CW'(N);
                        // Divide iterates on |a| with divisor |b|; multiply shifts |b| out against |a|
                        acc   <= is_div(op) ? {{N{1'b0}}, a_mag} : {{N{1'b0}}, b_mag};
                        opnd  <= is_div(op) ? b_mag : a_mag;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    m     <= m_fix;
                    r     <= r_fix;
                    error <= err_fix;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_multi_divid_seq.sv
// Directed table-driven bench for multi_divid_seq plus hand sequences for handshake corner cases.
module tb_multi_divid_seq;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] m;
    logic [N-1:0] r;
    logic         error;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] m;
        logic [N-1:0] r;
        logic         err;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    multi_divid_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .m     (m),
        .r     (r),
        .error (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after the capture edge; returns edges-to-done (0 on timeout) and busy-high samples
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        int nd;

        vecs[0]  = '{2'b00, 5'b01101, 5'b00010, 5'b00110, 5'b00001, 1'b0}; // 13/2
        vecs[1]  = '{2'b00, 5'b01010, 5'b11101, 5'b11101, 5'b00001, 1'b0}; // 10/-3
        vecs[2]  = '{2'b00, 5'b10010, 5'b11101, 5'b00100, 5'b11110, 1'b0}; // -14/-3
        vecs[3]  = '{2'b00, 5'b11001, 5'b00010, 5'b11101, 5'b11111, 1'b0}; // -7/2
        vecs[4]  = '{2'b01, 5'b11010, 5'b00111, 5'b11110, 5'b10110, 1'b0}; // -6*7
        vecs[5]  = '{2'b11, 5'b11010, 5'b00111, 5'b00101, 5'b10110, 1'b0}; // 26*7
        vecs[6]  = '{2'b00, 5'b01101, 5'b00000, 5'b11111, 5'b01101, 1'b1}; // div by zero
        vecs[7]  = '{2'b00, 5'b10000, 5'b11111, 5'b10000, 5'b00000, 1'b1}; // -16/-1 overflow
        vecs[8]  = '{2'b10, 5'b11001, 5'b00010, 5'b01100, 5'b00001, 1'b0}; // 25/2
        vecs[9]  = '{2'b10, 5'b10110, 5'b00000, 5'b11111, 5'b10110, 1'b1}; // unsigned div by zero
        vecs[10] = '{2'b01, 5'b10000, 5'b11111, 5'b00000, 5'b10000, 1'b0}; // -16*-1 = 16
        vecs[11] = '{2'b11, 5'b11111, 5'b11111, 5'b11110, 5'b00001, 1'b0}; // 31*31 = 961
        vecs[12] = '{2'b10, 5'b11111, 5'b00011, 5'b01010, 5'b00001, 1'b0}; // 31/3
        vecs[13] = '{2'b00, 5'b10000, 5'b00001, 5'b10000, 5'b00000, 1'b0}; // -16/1
        vecs[14] = '{2'b01, 5'b01111, 5'b01111, 5'b00111, 5'b00001, 1'b0}; // 15*15 = 225
        vecs[15] = '{2'b01, 5'b10000, 5'b10000, 5'b01000, 5'b00000, 1'b0}; // -16*-16 = 256

        #12;
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_m",     32'(m),     32'd0);
        check("reset_r",     32'(r),     32'd0);
        check("reset_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(N + 1));
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(N + 1));
            check($sformatf("v%0d_m", i), 32'(m), 32'(vecs[i].m));
            check($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].err));
            tick();
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_m_hold", i), 32'(m), 32'(vecs[i].m));
        end

        // start and operand changes while busy are ignored
        launch(2'b10, 5'b11001, 5'b00010);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                op = 2'b11; a = 5'b00011; b = 5'b00001; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check("ign_latency", 32'(lat), 32'(N + 1));
        check("ign_m", 32'(m), 32'd12);
        check("ign_r", 32'(r), 32'd1);
        check("ign_error", 32'(error), 32'd0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) nd++;
        end
        check("ign_no_extra_op", 32'(nd), 32'd0);
        check("ign_m_hold", 32'(m), 32'd12);

        // asynchronous reset mid-operation aborts without a done pulse
        launch(2'b01, 5'b11010, 5'b00111);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_done",  32'(done),  32'd0);
        check("arst_m",     32'(m),     32'd0);
        check("arst_r",     32'(r),     32'd0);
        check("arst_error", 32'(error), 32'd0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) nd++;
        end
        check("arst_no_done", 32'(nd), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        // start in the done cycle is accepted: back-to-back results N+2 edges apart
        launch(2'b11, 5'b11010, 5'b00111);
        wait_done(lat, bc);
        check("b2b_first_latency", 32'(lat), 32'(N + 1));
        check("b2b_first_m", 32'(m), 32'h05);
        check("b2b_first_r", 32'(r), 32'h16);
        launch(2'b00, 5'b01101, 5'b00010);
        check("b2b_second_busy", 32'(busy), 32'd1);
        wait_done(lat, bc);
        check("b2b_second_gap", 32'(lat + 1), 32'(N + 2));
        check("b2b_second_m", 32'(m), 32'd6);
        check("b2b_second_r", 32'(r), 32'd1);
        check("b2b_second_error", 32'(error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_divid_seq.md
Name: multi_divid_seq

Overview:
- Iterative, clocked successor to the combinational multiply/divide unit: same operand semantics, plus signed/unsigned modes and a start/done handshake.
- Width-parametrised radix-2 engine: shift-add multiply, restoring divide, one bit per cycle.
- Sits beside the ALU; replaces the combinational unit where N makes a single-cycle array too slow.

Parameters:
- N, 5, operand width in bits (N >= 2); results are two N-bit words.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle (busy=0).
- op  in  2  00 signed div, 01 signed mul, 10 unsigned div, 11 unsigned mul.
- a  in  N  dividend / multiplicand.
- b  in  N  divisor / multiplier.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; m/r/error valid.
- m  out  N  mul: high half of 2N-bit product; div: quotient.
- r  out  N  mul: low half of product; div: remainder.
- error  out  1  divide-by-zero or signed division overflow.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, error=0, m=0, r=0; counter and datapath registers cleared. Assertion mid-operation aborts with no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge k:
  - Latch op.
  - Latch operand magnitudes (abs value for signed ops, raw for unsigned).
  - Latch result sign flags and div-by-zero/overflow flags.
  - counter=N; busy=1; go to CALC.
- CALC: one iteration per edge (edges k+1..k+N); counter decrements; on counter reaching 0, go to FIX.
  - Mul: add multiplicand to upper accumulator if the accumulator LSB is 1, then shift right; 2N-bit accumulator.
  - Div: shift remainder:quotient left; trial-subtract divisor; keep if non-negative; set quotient bit.
- FIX, edge k+N+1:
  - Apply signs: product negated if sign(a)^sign(b); quotient negated if sign(a)^sign(b); remainder takes the sign of a (truncating division, |r| < |b|).
  - Register m, r, error; done=1; busy=0; go to IDLE.
- Latency: done rises N+1 edges after the start-capture edge, identically for every op, including error cases.
- done is high for exactly one cycle. m/r/error hold their values until the next FIX.
- start while busy=1: ignored, with no effect on the in-flight operation.
- start in the done cycle: accepted, since the state is already IDLE. Back-to-back throughput is one result per N+2 cycles.
- Operands and op are captured at edge k only; later changes on a/b/op are ignored.
- Divide by zero (b=0, op 00/10): error=1, m=all ones, r=a.
- Signed overflow (op 00, a=-2^(N-1), b=-1): error=1, m=-2^(N-1) (0x10..0), r=0.
- Multiply never sets error. The full 2N-bit product is exact for both signed and unsigned ops.
- Unsigned ops: no sign handling; operands are treated as 0..2^N-1.

Decomposition:
- Package multi_divid_pkg:
  - op codes OP_SDIV=2'b00, OP_SMUL=2'b01, OP_UDIV=2'b10, OP_UMUL=2'b11.
  - state enum IDLE/CALC/FIX.
  - helper functions is_div(op) and is_signed(op).
- Sub-module md_iter_step: purely combinational single iteration (mul add-shift or div subtract-shift on acc/operand registers, width parameter N). The top module owns the FSM, counter, sign fix and output registers.

Test Plan:
- N=5, op=00, a=01101 (13), b=00010 (2), start pulse -> done exactly 6 cycles later; m=6, r=1, error=0; busy high for those 6 cycles.
- op=00: a=01010, b=11101 -> m=-3, r=1. a=10010, b=11101 -> m=4, r=-2. a=11001, b=00010 -> m=-3, r=-1.
- op=01: a=11010, b=00111 -> m=-2 (11110), r=-10 (10110). op=11, same operands -> m=00101, r=10110 (182).
- op=00: a=01101, b=0 -> error=1, m=11111, r=01101. a=10000, b=11111 -> error=1, m=10000, r=0.
- op=10: a=11001 (25), b=00010 -> m=12, r=1. Raise start again 3 cycles in with other operands -> ignored; result unchanged.
- rst_n low at cycle 3 of an op -> all outputs 0 immediately, no done. Then a start in a done cycle -> accepted; second done after N+2 cycles total.
